// File: rtl/imm_narrow.sv
// imm_narrow: narrows a 16-bit value to a 5/8/11-bit immediate field and flags
// lossless round-trip. Optional auto width search under IMM_NARROW_AUTO_EN.
module imm_narrow #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        in_width,
  input  logic              in_signed,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_field,
  output logic [1:0]        out_width,
  output logic              out_fits,
  output logic [CNT_W-1:0]  ovf_count
);

  localparam logic [DATA_W-1:0] M5  = DATA_W'(32'h1F);
  localparam logic [DATA_W-1:0] M8  = DATA_W'(32'hFF);
  localparam logic [DATA_W-1:0] M11 = DATA_W'(32'h7FF);

  logic              s1_valid;
  logic [DATA_W-1:0] s1_data;
  logic [1:0]        s1_width;
  logic              s1_signed;

  logic              s2_valid;
  logic [DATA_W-1:0] s2_field;
  logic [1:0]        s2_width;
  logic              s2_fits;

  logic [CNT_W-1:0]  cnt;

  logic              s2_load;
  logic              s1_load;
  logic              xfer_in;
  logic              xfer_out;

  logic [DATA_W-1:0] c_field;
  logic [1:0]        c_width;
  logic              c_fits;

  function automatic logic fits_w(
    input logic [DATA_W-1:0] d,
    input logic [1:0]        w,
    input logic              sg
  );
    logic r;
    case (w)
      2'd1: r = sg ? (&d[DATA_W-1:4] | ~|d[DATA_W-1:4])
                   : ~|d[DATA_W-1:5];
      2'd2: r = sg ? (&d[DATA_W-1:7] | ~|d[DATA_W-1:7])
                   : ~|d[DATA_W-1:8];
      2'd3: r = sg ? (&d[DATA_W-1:10] | ~|d[DATA_W-1:10])
                   : ~|d[DATA_W-1:11];
      default: r = 1'b1;
    endcase
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] mask_w(
    input logic [DATA_W-1:0] d,
    input logic [1:0]        w
  );
    logic [DATA_W-1:0] r;
    case (w)
      2'd1:    r = d & M5;
      2'd2:    r = d & M8;
      2'd3:    r = d & M11;
      default: r = d;
    endcase
    return r;
  endfunction

  assign s2_load   = !s2_valid | out_ready;
  assign s1_load   = !s1_valid | s2_load;
  assign in_ready  = s1_load & !rst;
  assign out_valid = s2_valid & !rst;
  assign xfer_in   = in_valid & in_ready;
  assign xfer_out  = out_valid & out_ready;

  assign out_field = s2_field;
  assign out_width = s2_width;
  assign out_fits  = s2_fits;
  assign ovf_count = cnt;

  // Stage-2 datapath: field extraction, fit check, optional width search
  always_comb begin
    c_width = s1_width;
    c_fits  = fits_w(s1_data, s1_width, s1_signed);
    c_field = mask_w(s1_data, s1_width);
`ifdef IMM_NARROW_AUTO_EN
    if (s1_width == 2'd0) begin
      c_fits = 1'b1;
      if (fits_w(s1_data, 2'd1, s1_signed))
        c_width = 2'd1;
      else if (fits_w(s1_data, 2'd2, s1_signed))
        c_width = 2'd2;
      else if (fits_w(s1_data, 2'd3, s1_signed))
        c_width = 2'd3;
      else
        c_width = 2'd0;
      c_field = mask_w(s1_data, c_width);
    end
`endif
  end

  // Pipeline registers and saturating overflow counter
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_data   <= '0;
      s1_width  <= '0;
      s1_signed <= 1'b0;
      s2_valid  <= 1'b0;
      s2_field  <= '0;
      s2_width  <= '0;
      s2_fits   <= 1'b0;
      cnt       <= '0;
    end else begin
      if (s1_load) begin
        s1_valid <= xfer_in;
        if (xfer_in) begin
          s1_data   <= in_data;
          s1_width  <= in_width;
          s1_signed <= in_signed;
        end
      end
      if (s2_load) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_field <= c_field;
          s2_width <= c_width;
          s2_fits  <= c_fits;
        end
      end
      if (xfer_out && !s2_fits && cnt != '1)
        cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_imm_narrow.sv
// tb_imm_narrow: directed vector table plus stall, reset and
// counter saturation sequences for imm_narrow.
module tb_imm_narrow;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [1:0]  in_width;
  logic        in_signed;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_field;
  logic [1:0]  out_width;
  logic        out_fits;
  logic [7:0]  ovf_count;

  int total;
  int passed;
  int exp_cnt;

  typedef struct {
    logic [15:0] d;
    logic [1:0]  w;
    logic        s;
    logic [15:0] f;
    logic [1:0]  ew;
    logic        fits;
  } vec_t;

  vec_t vt[12];

  imm_narrow #(.DATA_W(16), .CNT_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_width(in_width),
    .in_signed(in_signed),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_field(out_field),
    .out_width(out_width),
    .out_fits(out_fits),
    .ovf_count(ovf_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h", name, act, exp);
    else
      passed++;
  endtask

  task automatic model_cnt(input logic fits);
    if (!fits && exp_cnt != 255)
      exp_cnt++;
  endtask

  initial begin
    total     = 0;
    passed    = 0;
    exp_cnt   = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_width  = '0;
    in_signed = 1'b0;
    out_ready = 1'b1;

    vt[0]  = '{16'hFFF0, 2'd1, 1'b1, 16'h0010, 2'd1, 1'b1};
    vt[1]  = '{16'h0010, 2'd1, 1'b1, 16'h0010, 2'd1, 1'b0};
    vt[2]  = '{16'h0010, 2'd1, 1'b0, 16'h0010, 2'd1, 1'b1};
    vt[3]  = '{16'h007F, 2'd2, 1'b1, 16'h007F, 2'd2, 1'b1};
    vt[4]  = '{16'h0080, 2'd2, 1'b1, 16'h0080, 2'd2, 1'b0};
    vt[5]  = '{16'h0080, 2'd2, 1'b0, 16'h0080, 2'd2, 1'b1};
    vt[6]  = '{16'hFC00, 2'd3, 1'b1, 16'h0400, 2'd3, 1'b1};
    vt[7]  = '{16'h7FFF, 2'd3, 1'b1, 16'h07FF, 2'd3, 1'b0};
    vt[8]  = '{16'hABCD, 2'd0, 1'b0, 16'hABCD, 2'd0, 1'b1};
`ifdef IMM_NARROW_AUTO_EN
    vt[9]  = '{16'h0002, 2'd0, 1'b1, 16'h0002, 2'd1, 1'b1};
`else
    vt[9]  = '{16'h0002, 2'd0, 1'b1, 16'h0002, 2'd0, 1'b1};
`endif
    vt[10] = '{16'h0400, 2'd0, 1'b1, 16'h0400, 2'd0, 1'b1};
    vt[11] = '{16'hFFFF, 2'd1, 1'b0, 16'h001F, 2'd1, 1'b0};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_field", 32'(out_field), 32'd0);
    chk("rst_out_width", 32'(out_width), 32'd0);
    chk("rst_out_fits", 32'(out_fits), 32'd0);
    chk("rst_ovf_count", 32'(ovf_count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // table vectors, one beat at a time
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      in_valid  = 1'b1;
      in_data   = vt[i].d;
      in_width  = vt[i].w;
      in_signed = vt[i].s;
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("v%0d_field", i), 32'(out_field), 32'(vt[i].f));
      chk($sformatf("v%0d_width", i), 32'(out_width), 32'(vt[i].ew));
      chk($sformatf("v%0d_fits", i), 32'(out_fits), 32'(vt[i].fits));
      chk($sformatf("v%0d_cnt", i), 32'(ovf_count), 32'(exp_cnt));
      model_cnt(vt[i].fits);
    end
    @(posedge clk);
    @(negedge clk);
    chk("tbl_cnt_final", 32'(ovf_count), 32'(exp_cnt));

    // stall: 4 beats with out_ready held low early on
    @(posedge clk);
    #1 out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          int t;
          t = 0;
          in_valid  = 1'b1;
          in_data   = 16'(i + 1);
          in_width  = 2'd2;
          in_signed = 1'b0;
          forever begin
            @(negedge clk);
            if (in_ready) break;
            t++;
            if (t > 50) break;
          end
          if (t > 50)
            chk("stall_in_timeout", 32'd1, 32'd0);
          @(posedge clk);
          #1;
        end
        in_valid = 1'b0;
      end
      begin
        int got;
        int cyc;
        got = 0;
        cyc = 0;
        repeat (3) @(negedge clk);
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_field0", 32'(out_field), 32'h0001);
        repeat (2) begin
          @(negedge clk);
          chk("stall_hold", 32'(out_field), 32'h0001);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        while (got < 4 && cyc < 40) begin
          @(negedge clk);
          cyc++;
          if (out_valid) begin
            chk($sformatf("stall_order%0d", got),
                32'(out_field), 32'(got + 1));
            got++;
          end
        end
        chk("stall_count", 32'(got), 32'd4);
      end
    join

    // reset with two beats in flight
    @(posedge clk);
    #1 out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h7FFF;
    in_width  = 2'd3;
    in_signed = 1'b1;
    repeat (2) @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_cnt", 32'(ovf_count), 32'(exp_cnt));
    rst = 1'b1;
    @(negedge clk);
    chk("in_rst_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    exp_cnt = 0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", 32'(out_valid), 32'd0);
    chk("post_rst_cnt", 32'(ovf_count), 32'd0);
    chk("post_rst_ready", 32'(in_ready), 32'd1);
    begin
      int seen;
      seen = 0;
      repeat (4) begin
        @(negedge clk);
        if (out_valid) seen++;
      end
      chk("no_stale", 32'(seen), 32'd0);
    end

    // counter saturation: 2^8+3 non-fitting beats
    @(posedge clk);
    #1;
    in_valid  = 1'b1;
    in_data   = 16'h7FFF;
    in_width  = 2'd3;
    in_signed = 1'b1;
    repeat (259) @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("sat_cnt", 32'(ovf_count), 32'hFF);
    @(posedge clk);
    #1 in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("sat_hold", 32'(ovf_count), 32'hFF);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
